// File: rtl/fetch_pkg.sv
// Shared constants and helpers for the instruction fetch stage.
package fetch_pkg;

    localparam int FETCH_BUF_DEPTH = 2;
    localparam int CNT_WIDTH       = $clog2(FETCH_BUF_DEPTH + 1);

    // True when buffered + in-flight entries, less the one being popped, leave room for a new read.
    function automatic logic can_issue(input logic [CNT_WIDTH-1:0] count,
                                       input logic                 inflight,
                                       input logic                 pop);
        logic [CNT_WIDTH:0] occ;
        occ = {1'b0, count} + {{CNT_WIDTH{1'b0}}, inflight} - {{CNT_WIDTH{1'b0}}, pop};
        return occ <= (CNT_WIDTH + 1)'(1);
    endfunction

endpackage

// File: rtl/fetch_buf.sv
// Two-entry instruction FIFO with a registered head so decode sees flop outputs.
module fetch_buf
    import fetch_pkg::*;
#(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  push,
    input  logic [ADDR_WIDTH-1:0] push_pc,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  pop,
    input  logic                  flush,
    output logic [CNT_WIDTH-1:0]  count,
    output logic [ADDR_WIDTH-1:0] head_pc,
    output logic [DATA_WIDTH-1:0] head_data
);

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] pc;
        logic [DATA_WIDTH-1:0] data;
    } entry_t;

    entry_t                head_q;
    entry_t                tail_q;
    entry_t                in_entry;
    logic [CNT_WIDTH-1:0]  count_q;

    assign in_entry  = '{pc: push_pc, data: push_data};
    assign count     = count_q;
    assign head_pc   = head_q.pc;
    assign head_data = head_q.data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else if (flush) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (count_q == '0) head_q <= in_entry;
                    else               tail_q <= in_entry;
                    count_q <= count_q + CNT_WIDTH'(1);
                end
                2'b01: begin
                    head_q  <= tail_q;
                    count_q <= count_q - CNT_WIDTH'(1);
                end
                2'b11: begin
                    // Occupancy unchanged; the new word lands behind whatever remains.
                    if (count_q == CNT_WIDTH'(FETCH_BUF_DEPTH)) begin
                        head_q <= tail_q;
                        tail_q <= in_entry;
                    end else begin
                        head_q <= in_entry;
                    end
                end
                default: ;
            endcase
        end
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(push && !pop && !flush && count_q == CNT_WIDTH'(FETCH_BUF_DEPTH)));

endmodule

// File: rtl/fetch_unit.sv
// Fetch stage: owns the PC, drives the synchronous ROM, and buffers returning words for decode.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 16,
    parameter int RESET_PC   = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    output logic [ADDR_WIDTH-1:0] rom_addr,
    input  logic [DATA_WIDTH-1:0] rom_data,
    input  logic                  redirect_valid,
    input  logic [ADDR_WIDTH-1:0] redirect_pc,
    output logic                  instr_valid,
    input  logic                  instr_ready,
    output logic [DATA_WIDTH-1:0] instr_data,
    output logic [ADDR_WIDTH-1:0] instr_pc
);

    logic [ADDR_WIDTH-1:0] pc;
    logic [ADDR_WIDTH-1:0] inflight_pc;
    logic                  inflight;
    logic [CNT_WIDTH-1:0]  count;
    logic                  pop;
    logic                  push;
    logic                  issue;

    assign rom_addr    = redirect_valid ? redirect_pc : pc;
    assign instr_valid = (count != '0);
    assign pop         = instr_valid && instr_ready;
    // A redirect discards both buffer and in-flight read, so it can always issue.
    assign issue       = redirect_valid || can_issue(count, inflight, pop);
    assign push        = inflight && !redirect_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc          <= ADDR_WIDTH'(RESET_PC);
            inflight    <= 1'b0;
            inflight_pc <= '0;
        end else if (issue) begin
            inflight_pc <= rom_addr;
            pc          <= rom_addr + ADDR_WIDTH'(1);
            inflight    <= 1'b1;
        end else begin
            inflight    <= 1'b0;
        end
    end

    fetch_buf #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_buf (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_pc   (inflight_pc),
        .push_data (rom_data),
        .pop       (pop),
        .flush     (redirect_valid),
        .count     (count),
        .head_pc   (instr_pc),
        .head_data (instr_data)
    );

endmodule
